// File: rtl/eth_axi_mem_pkg.sv
// Shared types for the eth_axi_mem_rsp AXI4 memory responder: FSM states, latched burst,
// AXI channel structs and burst/response encodings.
package eth_axi_mem_pkg;

    localparam int unsigned AxiAddrW = 32;
    localparam int unsigned AxiDataW = 32;
    localparam int unsigned AxiIdW   = 1;
    localparam int unsigned AxiUserW = 1;
    localparam int unsigned BeatCntW = 8;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_WRESP,
        ST_READ
    } state_e;

    typedef struct packed {
        logic [AxiIdW-1:0]   id;
        logic [AxiAddrW-1:0] addr;
        logic [7:0]          len;
        logic [2:0]          size;
        logic [1:0]          burst;
    } burst_t;

    typedef struct packed {
        logic [AxiIdW-1:0]   id;
        logic [AxiAddrW-1:0] addr;
        logic [7:0]          len;
        logic [2:0]          size;
        logic [1:0]          burst;
        logic                lock;
        logic [3:0]          cache;
        logic [2:0]          prot;
        logic [3:0]          qos;
        logic [3:0]          region;
        logic [5:0]          atop;
        logic [AxiUserW-1:0] user;
    } aw_chan_t;

    typedef struct packed {
        logic [AxiDataW-1:0]   data;
        logic [AxiDataW/8-1:0] strb;
        logic                  last;
        logic [AxiUserW-1:0]   user;
    } w_chan_t;

    typedef struct packed {
        logic [AxiIdW-1:0]   id;
        logic [1:0]          resp;
        logic [AxiUserW-1:0] user;
    } b_chan_t;

    typedef struct packed {
        logic [AxiIdW-1:0]   id;
        logic [AxiAddrW-1:0] addr;
        logic [7:0]          len;
        logic [2:0]          size;
        logic [1:0]          burst;
        logic                lock;
        logic [3:0]          cache;
        logic [2:0]          prot;
        logic [3:0]          qos;
        logic [3:0]          region;
        logic [AxiUserW-1:0] user;
    } ar_chan_t;

    typedef struct packed {
        logic [AxiIdW-1:0]   id;
        logic [AxiDataW-1:0] data;
        logic [1:0]          resp;
        logic                last;
        logic [AxiUserW-1:0] user;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } axi_mem_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } axi_mem_rsp_t;

endpackage

// File: rtl/eth_axi_mem_burst.sv
// Combinational AXI burst next-address generator (FIXED / INCR / WRAP), shared by
// the read and write paths of eth_axi_mem_rsp.
module eth_axi_mem_burst
    import eth_axi_mem_pkg::*;
#(
    parameter int unsigned AddrWidth = 32
) (
    input  logic [AddrWidth-1:0] addr_i,
    input  logic [2:0]           size_i,
    input  logic [7:0]           len_i,
    input  logic [1:0]           burst_i,
    output logic [AddrWidth-1:0] next_addr_o
);

    logic [AddrWidth-1:0] step;
    logic [AddrWidth-1:0] wrap_mask;
    logic [AddrWidth-1:0] incr_addr;

    always_comb begin
        step      = AddrWidth'(1) << size_i;
        // Window is (len+1) beats of 2^size bytes, aligned to its own size.
        wrap_mask = ((AddrWidth'(len_i) + AddrWidth'(1)) << size_i) - AddrWidth'(1);
        incr_addr = addr_i + step;
        case (burst_i)
            BURST_FIXED: next_addr_o = addr_i;
            BURST_WRAP:  next_addr_o = (addr_i & ~wrap_mask) | (incr_addr & wrap_mask);
            default:     next_addr_o = incr_addr;
        endcase
    end

endmodule

// File: rtl/eth_axi_mem_rsp.sv
// AXI4 single-burst responder over a word memory. Define ETH_AXI_MEM_ERR_EN to flag
// out-of-range beats with SLVERR; otherwise addresses alias modulo the memory size.
module eth_axi_mem_rsp
    import eth_axi_mem_pkg::*;
#(
    parameter int unsigned          DataWidth  = 32,
    parameter int unsigned          AddrWidth  = 32,
    parameter int unsigned          AxiIdWidth = 1,
    parameter int unsigned          UserWidth  = 1,
    parameter int unsigned          MemWords   = 1024,
    parameter logic [AddrWidth-1:0] BaseAddr   = '0,
    parameter type                  axi_req_t  = eth_axi_mem_pkg::axi_mem_req_t,
    parameter type                  axi_rsp_t  = eth_axi_mem_pkg::axi_mem_rsp_t
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  axi_req_t axi_req_i,
    output axi_rsp_t axi_rsp_o
);

    localparam int unsigned OffW = $clog2(DataWidth/8);
    localparam int unsigned IdxW = $clog2(MemWords);

    state_e                state_q, state_d;
    burst_t                burst_q, burst_d;
    logic [BeatCntW-1:0]   cnt_q, cnt_d;
    logic                  prio_q, prio_d;
    logic                  err_q, err_d;
    logic [DataWidth-1:0]  mem_q [MemWords];

    logic [AddrWidth-1:0]  next_addr;
    logic [AddrWidth-1:0]  mem_off;
    logic [IdxW-1:0]       mem_idx;
    logic                  addr_ok;
    logic                  contend, aw_rdy, ar_rdy;
    logic                  aw_hs, ar_hs, w_hs, b_hs, r_hs, rlast;
    logic                  unused_bits;

    eth_axi_mem_burst #(.AddrWidth(AddrWidth)) u_burst (
        .addr_i      (burst_q.addr),
        .size_i      (burst_q.size),
        .len_i       (burst_q.len),
        .burst_i     (burst_q.burst),
        .next_addr_o (next_addr)
    );

    assign mem_off = burst_q.addr - BaseAddr;
    assign mem_idx = mem_off[OffW +: IdxW];

`ifdef ETH_AXI_MEM_ERR_EN
    localparam logic [AddrWidth:0] MemBytes = (AddrWidth+1)'(MemWords*(DataWidth/8));
    assign addr_ok = ({1'b0, mem_off} < MemBytes);
`else
    assign addr_ok = 1'b1;
`endif

    // Priority only matters on contention; 0 = write-first.
    assign contend = axi_req_i.aw_valid & axi_req_i.ar_valid;
    assign aw_rdy  = (state_q == ST_IDLE) & ~rst_i & (~contend | ~prio_q);
    assign ar_rdy  = (state_q == ST_IDLE) & ~rst_i & (~contend |  prio_q);
    assign aw_hs   = axi_req_i.aw_valid & aw_rdy;
    assign ar_hs   = axi_req_i.ar_valid & ar_rdy;
    assign w_hs    = (state_q == ST_WRITE) & axi_req_i.w_valid;
    assign b_hs    = (state_q == ST_WRESP) & axi_req_i.b_ready;
    assign r_hs    = (state_q == ST_READ)  & axi_req_i.r_ready;
    assign rlast   = (cnt_q == burst_q.len);

    // awatop, cache, prot, qos etc. are accepted but have no effect.
    assign unused_bits = ^{axi_req_i, mem_off};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            burst_q <= '0;
            cnt_q   <= '0;
            prio_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            burst_q <= burst_d;
            cnt_q   <= cnt_d;
            prio_q  <= prio_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        burst_d = burst_q;
        cnt_d   = cnt_q;
        prio_d  = prio_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (aw_hs) begin
                    burst_d = '{id: axi_req_i.aw.id, addr: axi_req_i.aw.addr, len: axi_req_i.aw.len,
                                size: axi_req_i.aw.size, burst: axi_req_i.aw.burst};
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    prio_d  = ~prio_q;
                    state_d = ST_WRITE;
                end else if (ar_hs) begin
                    burst_d = '{id: axi_req_i.ar.id, addr: axi_req_i.ar.addr, len: axi_req_i.ar.len,
                                size: axi_req_i.ar.size, burst: axi_req_i.ar.burst};
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    prio_d  = ~prio_q;
                    state_d = ST_READ;
                end
            end
            ST_WRITE: begin
                if (w_hs) begin
                    burst_d.addr = next_addr;
                    cnt_d        = cnt_q + BeatCntW'(1);
                    err_d        = err_q | ~addr_ok;
                    if (axi_req_i.w.last) state_d = ST_WRESP;
                end
            end
            ST_WRESP: begin
                if (b_hs) state_d = ST_IDLE;
            end
            ST_READ: begin
                if (r_hs) begin
                    burst_d.addr = next_addr;
                    cnt_d        = cnt_q + BeatCntW'(1);
                    if (rlast) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        axi_rsp_o          = '0;
        axi_rsp_o.aw_ready = aw_rdy;
        axi_rsp_o.ar_ready = ar_rdy;
        axi_rsp_o.w_ready  = (state_q == ST_WRITE);
        if (state_q == ST_WRESP) begin
            axi_rsp_o.b_valid = 1'b1;
            axi_rsp_o.b.id    = AxiIdWidth'(burst_q.id);
            axi_rsp_o.b.resp  = err_q ? RESP_SLVERR : RESP_OKAY;
            axi_rsp_o.b.user  = UserWidth'(0);
        end
        if (state_q == ST_READ) begin
            axi_rsp_o.r_valid = 1'b1;
            axi_rsp_o.r.id    = AxiIdWidth'(burst_q.id);
            axi_rsp_o.r.data  = addr_ok ? mem_q[mem_idx] : '0;
            axi_rsp_o.r.resp  = addr_ok ? RESP_OKAY : RESP_SLVERR;
            axi_rsp_o.r.last  = rlast;
            axi_rsp_o.r.user  = UserWidth'(0);
        end
    end

    // Memory is deliberately outside reset so contents survive rst_i.
    always_ff @(posedge clk_i) begin
        if (w_hs && addr_ok) begin
            for (int i = 0; i < DataWidth/8; i++) begin
                if (axi_req_i.w.strb[i]) mem_q[mem_idx][i*8 +: 8] <= axi_req_i.w.data[i*8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_eth_axi_mem_rsp.sv
// Directed bench for eth_axi_mem_rsp with a read-data scoreboard queue.
module tb_eth_axi_mem_rsp;
    import eth_axi_mem_pkg::*;

    localparam logic [31:0] BASE = 32'h0;

    logic         clk = 1'b0;
    logic         rst;
    axi_mem_req_t req;
    axi_mem_rsp_t rsp;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } rexp_t;

    rexp_t       exp_q [$];
    logic [31:0] wdata_a [16];
    logic [3:0]  wstrb_a [16];
    logic [31:0] rdata_a [16];
    logic [1:0]  rresp_a [16];

    always #5 clk = ~clk;

    eth_axi_mem_rsp #(
        .DataWidth  (32),
        .AddrWidth  (32),
        .AxiIdWidth (1),
        .UserWidth  (1),
        .MemWords   (1024),
        .BaseAddr   (BASE),
        .axi_req_t  (axi_mem_req_t),
        .axi_rsp_t  (axi_mem_rsp_t)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .axi_req_i (req),
        .axi_rsp_o (rsp)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic send_aw(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input logic id);
        bit got = 1'b0;
        req.aw.id    = id;
        req.aw.addr  = addr;
        req.aw.len   = len;
        req.aw.size  = 3'd2;
        req.aw.burst = burst;
        req.aw_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp.aw_ready) begin got = 1'b1; break; end
        end
        check("aw_handshake", 32'(got), 32'd1);
        @(posedge clk); #1;
        req.aw_valid = 1'b0;
    endtask

    task automatic send_ar(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input logic id);
        bit got = 1'b0;
        req.ar.id    = id;
        req.ar.addr  = addr;
        req.ar.len   = len;
        req.ar.size  = 3'd2;
        req.ar.burst = burst;
        req.ar_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp.ar_ready) begin got = 1'b1; break; end
        end
        check("ar_handshake", 32'(got), 32'd1);
        @(posedge clk); #1;
        req.ar_valid = 1'b0;
    endtask

    task automatic send_w(input int n);
        for (int i = 0; i < n; i++) begin
            bit got = 1'b0;
            req.w.data  = wdata_a[i];
            req.w.strb  = wstrb_a[i];
            req.w.last  = (i == n-1);
            req.w_valid = 1'b1;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (rsp.w_ready) begin got = 1'b1; break; end
            end
            if (!got) check("w_handshake", 32'(got), 32'd1);
            @(posedge clk); #1;
        end
        req.w_valid = 1'b0;
        req.w.last  = 1'b0;
    endtask

    task automatic recv_b(input logic [1:0] exp_resp, input logic exp_id);
        @(negedge clk);
        check("bvalid_rise", 32'(rsp.b_valid), 32'd1);
        check("bresp", 32'(rsp.b.resp), 32'(exp_resp));
        check("bid", 32'(rsp.b.id), 32'(exp_id));
        req.b_ready = 1'b1;
        @(posedge clk); #1;
        req.b_ready = 1'b0;
        check("bvalid_fall", 32'(rsp.b_valid), 32'd0);
    endtask

    task automatic push_r(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back('{data: rdata_a[i], resp: rresp_a[i]});
    endtask

    task automatic recv_r(input logic [7:0] len, input logic exp_id, input int n, input int stall);
        rexp_t e;
        req.r_ready = 1'b1;
        for (int b = 0; b < n; b++) begin
            if (b == stall) begin
                req.r_ready = 1'b0;
                @(posedge clk); #1;
                check("rvalid_hold", 32'(rsp.r_valid), 32'd1);
                req.r_ready = 1'b1;
            end
            @(negedge clk);
            check("rvalid", 32'(rsp.r_valid), 32'd1);
            if (exp_q.size() == 0) begin
                check("r_scoreboard_empty", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("rdata", rsp.r.data, e.data);
                check("rresp", 32'(rsp.r.resp), 32'(e.resp));
            end
            check("rlast", 32'(rsp.r.last), 32'(b == int'(len)));
            check("rid", 32'(rsp.r.id), 32'(exp_id));
            @(posedge clk); #1;
        end
        if (n == int'(len) + 1) begin
            req.r_ready = 1'b0;
            check("rvalid_fall", 32'(rsp.r_valid), 32'd0);
        end
    endtask

    task automatic write_burst(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                               input logic id, input logic [1:0] exp_resp);
        send_aw(addr, len, burst, id);
        send_w(int'(len) + 1);
        recv_b(exp_resp, id);
    endtask

    task automatic read_burst(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                              input logic id, input int stall);
        send_ar(addr, len, burst, id);
        push_r(int'(len) + 1);
        recv_r(len, id, int'(len) + 1, stall);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running required=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        req = '0;
        rst = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wstrb_a[i] = 4'hF;
            rresp_a[i] = RESP_OKAY;
        end

        repeat (3) @(posedge clk);
        #1;
        check("rst_awready", 32'(rsp.aw_ready), 32'd0);
        check("rst_arready", 32'(rsp.ar_ready), 32'd0);
        check("rst_wready",  32'(rsp.w_ready),  32'd0);
        check("rst_bvalid",  32'(rsp.b_valid),  32'd0);
        check("rst_rvalid",  32'(rsp.r_valid),  32'd0);
        check("rst_rdata",   rsp.r.data,        32'd0);
        check("rst_rlast",   32'(rsp.r.last),   32'd0);
        check("rst_bresp",   32'(rsp.b.resp),   32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_awready", 32'(rsp.aw_ready), 32'd1);
        check("post_rst_arready", 32'(rsp.ar_ready), 32'd1);
        @(posedge clk); #1;

        // INCR write then read with one stalled beat
        wdata_a[0] = 32'h11; wdata_a[1] = 32'h22; wdata_a[2] = 32'h33; wdata_a[3] = 32'h44;
        write_burst(BASE + 32'h10, 8'd3, BURST_INCR, 1'b1, RESP_OKAY);
        rdata_a[0] = 32'h11; rdata_a[1] = 32'h22; rdata_a[2] = 32'h33; rdata_a[3] = 32'h44;
        read_burst(BASE + 32'h10, 8'd3, BURST_INCR, 1'b1, 1);

        // Strobe merge
        wdata_a[0] = 32'hAABBCCDD; wstrb_a[0] = 4'hF;
        write_burst(BASE + 32'h40, 8'd0, BURST_INCR, 1'b0, RESP_OKAY);
        wdata_a[0] = 32'h11223344; wstrb_a[0] = 4'h5;
        write_burst(BASE + 32'h40, 8'd0, BURST_INCR, 1'b0, RESP_OKAY);
        wstrb_a[0] = 4'hF;
        rdata_a[0] = 32'hAA22CC44;
        read_burst(BASE + 32'h40, 8'd0, BURST_INCR, 1'b0, -1);

        // WRAP from 0x08: beats land at 0x08, 0x0C, 0x00, 0x04
        wdata_a[0] = 32'hA0000000; wdata_a[1] = 32'hA0000001;
        wdata_a[2] = 32'hA0000002; wdata_a[3] = 32'hA0000003;
        write_burst(BASE + 32'h08, 8'd3, BURST_WRAP, 1'b0, RESP_OKAY);
        rdata_a[0] = 32'hA0000002; rdata_a[1] = 32'hA0000003;
        rdata_a[2] = 32'hA0000000; rdata_a[3] = 32'hA0000001;
        read_burst(BASE + 32'h00, 8'd3, BURST_INCR, 1'b0, -1);

        // FIXED: last beat wins, FIXED read repeats the word
        wdata_a[0] = 32'hF1; wdata_a[1] = 32'hF2; wdata_a[2] = 32'hF3;
        write_burst(BASE + 32'h80, 8'd2, BURST_FIXED, 1'b1, RESP_OKAY);
        rdata_a[0] = 32'hF3; rdata_a[1] = 32'hF3;
        read_burst(BASE + 32'h80, 8'd1, BURST_FIXED, 1'b1, -1);

        // Simultaneous AW/AR after reset
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        req.aw.id = 1'b0; req.aw.addr = BASE + 32'h200; req.aw.len = 8'd0;
        req.aw.size = 3'd2; req.aw.burst = BURST_INCR; req.aw_valid = 1'b1;
        req.ar.id = 1'b1; req.ar.addr = BASE + 32'h10; req.ar.len = 8'd0;
        req.ar.size = 3'd2; req.ar.burst = BURST_INCR; req.ar_valid = 1'b1;
        @(negedge clk);
        check("prio1_awready", 32'(rsp.aw_ready), 32'd1);
        check("prio1_arready", 32'(rsp.ar_ready), 32'd0);
        @(posedge clk); #1;
        req.aw_valid = 1'b0;
        wdata_a[0] = 32'h55;
        send_w(1);
        recv_b(RESP_OKAY, 1'b0);
        req.aw.addr = BASE + 32'h204; req.aw_valid = 1'b1;
        @(negedge clk);
        check("prio2_arready", 32'(rsp.ar_ready), 32'd1);
        check("prio2_awready", 32'(rsp.aw_ready), 32'd0);
        @(posedge clk); #1;
        req.ar_valid = 1'b0;
        rdata_a[0] = 32'h11;
        push_r(1);
        recv_r(8'd0, 1'b1, 1, -1);
        @(negedge clk);
        check("prio3_awready", 32'(rsp.aw_ready), 32'd1);
        @(posedge clk); #1;
        req.aw_valid = 1'b0;
        wdata_a[0] = 32'h66;
        send_w(1);
        recv_b(RESP_OKAY, 1'b0);
        rdata_a[0] = 32'h55; rdata_a[1] = 32'h66;
        read_burst(BASE + 32'h200, 8'd1, BURST_INCR, 1'b0, -1);

        // Reset on beat 2 of a len-7 read
        for (int i = 0; i < 8; i++) wdata_a[i] = 32'h1000 + i;
        write_burst(BASE + 32'h300, 8'd7, BURST_INCR, 1'b0, RESP_OKAY);
        for (int i = 0; i < 8; i++) rdata_a[i] = 32'h1000 + i;
        send_ar(BASE + 32'h300, 8'd7, BURST_INCR, 1'b1);
        push_r(8);
        recv_r(8'd7, 1'b1, 2, -1);
        @(negedge clk);
        check("beat2_rdata", rsp.r.data, 32'h1002);
        rst = 1'b1;
        #1;
        check("rst_mid_rvalid",  32'(rsp.r_valid),  32'd0);
        check("rst_mid_arready", 32'(rsp.ar_ready), 32'd0);
        exp_q.delete();
        req.r_ready = 1'b0;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        read_burst(BASE + 32'h300, 8'd7, BURST_INCR, 1'b1, -1);

`ifdef ETH_AXI_MEM_ERR_EN
        wdata_a[0] = 32'hDEADBEEF; wdata_a[1] = 32'hDEADBEEF;
        write_burst(BASE + 32'h1000, 8'd1, BURST_INCR, 1'b0, RESP_SLVERR);
        rdata_a[0] = 32'hA0000002; rresp_a[0] = RESP_OKAY;
        read_burst(BASE + 32'h0, 8'd0, BURST_INCR, 1'b0, -1);
        rdata_a[0] = 32'h0; rresp_a[0] = RESP_SLVERR;
        read_burst(BASE + 32'h1000, 8'd0, BURST_INCR, 1'b0, -1);
`else
        wdata_a[0] = 32'hCAFE0001;
        write_burst(BASE + 32'h1000, 8'd0, BURST_INCR, 1'b0, RESP_OKAY);
        rdata_a[0] = 32'hCAFE0001; rresp_a[0] = RESP_OKAY;
        read_burst(BASE + 32'h0, 8'd0, BURST_INCR, 1'b0, -1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
